cache_req_arb: RTL and testbench
================================

Name: cache_req_arb

Overview:
- Two-client line-request arbiter that sits directly upstream of the bus interface unit's cache port.
- Accepts 512-bit line requests from the icache (read-only) and the dcache (read/write). Grants one client round-robin, forwards a single request downstream, and routes the single response back to the owning client.
- One transaction outstanding at a time.

Parameters:
ADDR_W, 64, request address width
LINE_W, 512, cache line data width
LINE_OFF_W, 6, low address bits cleared on forwarded addresses (line alignment)
TIMEOUT_CYC, 1023, response watchdog limit in cycles; used only with CACHE_ARB_TIMEOUT_EN

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ic_req_vld_i  in  1  icache request valid
ic_req_rdy_o  out  1  icache request ready
ic_req_addr_i  in  ADDR_W  icache line address
ic_resp_vld_o  out  1  icache response valid
ic_resp_rdy_i  in  1  icache response ready
ic_resp_rdata_o  out  LINE_W  icache response line
ic_resp_err_o  out  1  icache response error
dc_req_vld_i  in  1  dcache request valid
dc_req_rdy_o  out  1  dcache request ready
dc_req_rd_i  in  1  1=read, 0=write
dc_req_addr_i  in  ADDR_W  dcache line address
dc_req_wdata_i  in  LINE_W  dcache write line
dc_resp_vld_o  out  1  dcache response valid
dc_resp_rdy_i  in  1  dcache response ready
dc_resp_rdata_o  out  LINE_W  dcache response line
dc_resp_err_o  out  1  dcache response error
cache_req_vld_o  out  1  downstream request valid
cache_req_rdy_i  in  1  downstream request ready
cache_req_rd_o  out  1  downstream read/write
cache_req_addr_o  out  ADDR_W  downstream line-aligned address
cache_req_wdata_o  out  LINE_W  downstream write line
cache_resp_vld_i  in  1  downstream response valid (may be a one-cycle pulse)
cache_resp_rdy_o  out  1  downstream response ready
cache_resp_rdata_i  in  LINE_W  downstream response line
cache_resp_err_i  in  1  downstream response error

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low.
- Reset values: state=IDLE; last_grant=DC, so the icache wins the first tie; owner, req_rd, req_addr, req_wdata, rsp_data, rsp_err all 0. After reset every vld/rdy output is 0 and all data outputs are 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - gnt_ic = ic_vld & (~dc_vld | last_grant==DC); gnt_dc = dc_vld & ~gnt_ic.
  - ic_req_rdy_o=gnt_ic and dc_req_rdy_o=gnt_dc, both combinational; both are 0 outside IDLE.
  - On a grant, latch owner and last_grant, latch address with the low LINE_OFF_W bits forced to 0, and latch rd. The icache forces rd=1 and wdata=0; the dcache latches dc rd and wdata. Go to REQ.
- REQ:
  - cache_req_vld_o=1, driven from registers; it holds stable until cache_req_rdy_i.
  - On handshake go to WAIT.
- WAIT:
  - cache_resp_rdy_o=1.
  - When cache_resp_vld_i is high, capture rdata/err and go to RESP.
  - Must never backpressure, because the downstream response is a pulse.
- RESP:
  - The owner's resp_vld_o=1 with the captured data/err; the non-owner's resp_vld_o=0.
  - Hold until the owner's resp_rdy_i is high, then go to IDLE.
- Latency: request accepted at cycle N → cache_req_vld_o high at N+1. Downstream response at M → client resp_vld_o at M+1. After a RESP handshake, the earliest next grant is the following cycle (IDLE).
- Response rdata/err outputs are driven only to the owner; the non-owner's outputs are 0.
- Simultaneous valids: alternate strictly, IC, DC, IC, ... A single requester is granted every time regardless of last_grant.
- A client dropping vld while not granted is legal; no state changes.
- cache_resp_vld_i outside WAIT is ignored (cache_resp_rdy_o=0).
- Reset asserted mid-transaction: the arbiter returns to IDLE next cycle, the in-flight transaction is abandoned, and no client response is produced.

Optional Feature:
CACHE_ARB_TIMEOUT_EN
- Defined:
  - A counter of width clog2(TIMEOUT_CYC+1) clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYC without a response, go to RESP with rdata=0 and err=1, and set drop_pending.
  - While drop_pending=1, cache_resp_rdy_o=1 in every state. The next cache_resp_vld_i is discarded and clears drop_pending; no grant is issued while drop_pending=1.
- Undefined: no counter, no drop_pending; WAIT lasts indefinitely.

Test Plan:
- IC read only: ic addr=0x8000_1234, downstream rdy immediately, response 3 cycles later with data=pattern A, err=0 → cache_req_addr_o=0x8000_1200, rd_o=1, wdata_o=0. ic_resp_vld_o 1 cycle after the response with data A; dc_resp_vld_o stays 0.
- DC write: rd=0, addr=0x40, wdata=pattern B, cache_req_rdy_i held low 5 cycles → vld_o, addr, and wdata stable for 6 cycles. Response err=1 → dc_resp_err_o=1.
- Both valid continuously for 4 transactions after reset → grant order IC, DC, IC, DC, with exactly one downstream request per grant.
- Response backpressure: dc_resp_rdy_i low 4 cycles after a one-cycle cache_resp_vld_i pulse → dc_resp_vld_o held 5 cycles with data unchanged. No new grant occurs until the handshake.
- Reset asserted in WAIT with ic_req_vld_i still high → next cycle all outputs are 0. The following IDLE cycle grants IC.
- With CACHE_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: no response → owner gets err=1, data=0, and the next grant is blocked. A late response pulse is absorbed, and granting then resumes.

Source files
------------

// File: rtl/cache_req_arb.sv
// cache_req_arb: two-client cache line request arbiter in front of the BIU cache port.
//
// The icache (read-only) and the dcache (read/write) each present 512-bit line
// requests. A round-robin grant picks one client. A single request is forwarded
// downstream with a line-aligned address. The single response is then routed back
// to the client that owns the transaction. Only one transaction is outstanding.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ic_req_*  / ic_resp_* icache request (valid/ready/addr) and response channel
//   dc_req_*  / dc_resp_* dcache request (valid/ready/rd/addr/wdata) and response
//   cache_req_*           downstream request (valid/ready/rd/addr/wdata)
//   cache_resp_*          downstream response (valid pulse, ready, rdata, err)
//
// Optional build macro CACHE_ARB_TIMEOUT_EN adds a response watchdog. After
// TIMEOUT_CYC cycles in WAIT, the owner gets an error response. The late downstream
// response is then absorbed before any new grant is issued.

module cache_req_arb #(
    parameter int ADDR_W      = 64,
    parameter int LINE_W      = 512,
    parameter int LINE_OFF_W  = 6,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req_vld_i,
    output logic              ic_req_rdy_o,
    input  logic [ADDR_W-1:0] ic_req_addr_i,
    output logic              ic_resp_vld_o,
    input  logic              ic_resp_rdy_i,
    output logic [LINE_W-1:0] ic_resp_rdata_o,
    output logic              ic_resp_err_o,
    input  logic              dc_req_vld_i,
    output logic              dc_req_rdy_o,
    input  logic              dc_req_rd_i,
    input  logic [ADDR_W-1:0] dc_req_addr_i,
    input  logic [LINE_W-1:0] dc_req_wdata_i,
    output logic              dc_resp_vld_o,
    input  logic              dc_resp_rdy_i,
    output logic [LINE_W-1:0] dc_resp_rdata_o,
    output logic              dc_resp_err_o,
    output logic              cache_req_vld_o,
    input  logic              cache_req_rdy_i,
    output logic              cache_req_rd_o,
    output logic [ADDR_W-1:0] cache_req_addr_o,
    output logic [LINE_W-1:0] cache_req_wdata_o,
    input  logic              cache_resp_vld_i,
    output logic              cache_resp_rdy_o,
    input  logic [LINE_W-1:0] cache_resp_rdata_i,
    input  logic              cache_resp_err_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic CL_IC = 1'b0;
    localparam logic CL_DC = 1'b1;
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1) << LINE_OFF_W) - ADDR_W'(1));

    state_t            state, state_nxt;
    logic              last_grant;
    logic              owner;
    logic              req_rd;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic [LINE_W-1:0] rsp_data;
    logic              rsp_err;

    logic grant_ok, gnt_ic, gnt_dc, owner_rdy, rsp_capture, timeout;

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             drop_pending;

    assign timeout = (state == WAIT) && !cache_resp_vld_i &&
                     (to_cnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt       <= '0;
            drop_pending <= 1'b0;
        end else begin
            if (state == REQ && cache_req_rdy_i)
                to_cnt <= '0;
            else if (state == WAIT && to_cnt != CNT_W'(TIMEOUT_CYC))
                to_cnt <= to_cnt + CNT_W'(1);

            // The timed-out transaction still owes one downstream response.
            // Swallow that response before a new request can go out.
            if (timeout)
                drop_pending <= 1'b1;
            else if (drop_pending && cache_resp_vld_i)
                drop_pending <= 1'b0;
        end
    end

    assign grant_ok         = rst_n && (state == IDLE) && !drop_pending;
    assign cache_resp_rdy_o = (state == WAIT) || drop_pending;
`else
    assign timeout          = 1'b0;
    assign grant_ok         = rst_n && (state == IDLE);
    assign cache_resp_rdy_o = (state == WAIT);
`endif

    // Round robin: on a tie, icache wins unless it took the previous grant.
    // Ready is gated by rst_n so no handshake is accepted while reset is held.
    assign gnt_ic = grant_ok && ic_req_vld_i && (!dc_req_vld_i || last_grant == CL_DC);
    assign gnt_dc = grant_ok && dc_req_vld_i && !gnt_ic;

    assign ic_req_rdy_o = gnt_ic;
    assign dc_req_rdy_o = gnt_dc;

    assign owner_rdy   = (owner == CL_DC) ? dc_resp_rdy_i : ic_resp_rdy_i;
    assign rsp_capture = (state == WAIT) && cache_resp_vld_i;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (gnt_ic || gnt_dc)           state_nxt = REQ;
            REQ:  if (cache_req_rdy_i)            state_nxt = WAIT;
            WAIT: if (rsp_capture || timeout)     state_nxt = RESP;
            RESP: if (owner_rdy)                  state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= CL_DC;
            owner      <= CL_IC;
            req_rd     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (gnt_ic) begin
                last_grant <= CL_IC;
                owner      <= CL_IC;
                req_rd     <= 1'b1;
                req_addr   <= ic_req_addr_i & LINE_MASK;
                req_wdata  <= '0;
            end else if (gnt_dc) begin
                last_grant <= CL_DC;
                owner      <= CL_DC;
                req_rd     <= dc_req_rd_i;
                req_addr   <= dc_req_addr_i & LINE_MASK;
                req_wdata  <= dc_req_wdata_i;
            end

            if (rsp_capture) begin
                rsp_data <= cache_resp_rdata_i;
                rsp_err  <= cache_resp_err_i;
            end else if (timeout) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end

    assign cache_req_vld_o   = (state == REQ);
    assign cache_req_rd_o    = req_rd;
    assign cache_req_addr_o  = req_addr;
    assign cache_req_wdata_o = req_wdata;

    // The non-owner's response outputs stay at zero.
    assign ic_resp_vld_o   = (state == RESP) && (owner == CL_IC);
    assign dc_resp_vld_o   = (state == RESP) && (owner == CL_DC);
    assign ic_resp_rdata_o = ic_resp_vld_o ? rsp_data : '0;
    assign ic_resp_err_o   = ic_resp_vld_o && rsp_err;
    assign dc_resp_rdata_o = dc_resp_vld_o ? rsp_data : '0;
    assign dc_resp_err_o   = dc_resp_vld_o && rsp_err;

endmodule

// File: tb/tb_cache_req_arb.sv
// Directed bench for cache_req_arb. Expected values are hand-computed.
// Build with CACHE_ARB_TIMEOUT_EN defined to also run the watchdog scenario,
// which uses TIMEOUT_CYC=8.

module tb_cache_req_arb;

    localparam int ADDR_W = 64;
    localparam int LINE_W = 512;
    localparam logic [LINE_W-1:0] PAT_A = {16{32'hA5A5_0001}};
    localparam logic [LINE_W-1:0] PAT_B = {16{32'h5A5A_00B2}};
    localparam logic [LINE_W-1:0] PAT_C = {16{32'h0C0C_C0C0}};
    localparam logic [LINE_W-1:0] PAT_D = {16{32'hDEAD_BEEF}};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ic_req_vld_i, ic_req_rdy_o;
    logic [ADDR_W-1:0] ic_req_addr_i;
    logic              ic_resp_vld_o, ic_resp_rdy_i, ic_resp_err_o;
    logic [LINE_W-1:0] ic_resp_rdata_o;
    logic              dc_req_vld_i, dc_req_rdy_o, dc_req_rd_i;
    logic [ADDR_W-1:0] dc_req_addr_i;
    logic [LINE_W-1:0] dc_req_wdata_i;
    logic              dc_resp_vld_o, dc_resp_rdy_i, dc_resp_err_o;
    logic [LINE_W-1:0] dc_resp_rdata_o;
    logic              cache_req_vld_o, cache_req_rdy_i, cache_req_rd_o;
    logic [ADDR_W-1:0] cache_req_addr_o;
    logic [LINE_W-1:0] cache_req_wdata_o;
    logic              cache_resp_vld_i, cache_resp_rdy_o, cache_resp_err_i;
    logic [LINE_W-1:0] cache_resp_rdata_i;

    int n_vec  = 0;
    int n_miss = 0;

    cache_req_arb #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .LINE_OFF_W(6), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req_vld_i(ic_req_vld_i), .ic_req_rdy_o(ic_req_rdy_o), .ic_req_addr_i(ic_req_addr_i),
        .ic_resp_vld_o(ic_resp_vld_o), .ic_resp_rdy_i(ic_resp_rdy_i),
        .ic_resp_rdata_o(ic_resp_rdata_o), .ic_resp_err_o(ic_resp_err_o),
        .dc_req_vld_i(dc_req_vld_i), .dc_req_rdy_o(dc_req_rdy_o), .dc_req_rd_i(dc_req_rd_i),
        .dc_req_addr_i(dc_req_addr_i), .dc_req_wdata_i(dc_req_wdata_i),
        .dc_resp_vld_o(dc_resp_vld_o), .dc_resp_rdy_i(dc_resp_rdy_i),
        .dc_resp_rdata_o(dc_resp_rdata_o), .dc_resp_err_o(dc_resp_err_o),
        .cache_req_vld_o(cache_req_vld_o), .cache_req_rdy_i(cache_req_rdy_i),
        .cache_req_rd_o(cache_req_rd_o), .cache_req_addr_o(cache_req_addr_o),
        .cache_req_wdata_o(cache_req_wdata_o),
        .cache_resp_vld_i(cache_resp_vld_i), .cache_resp_rdy_o(cache_resp_rdy_o),
        .cache_resp_rdata_i(cache_resp_rdata_i), .cache_resp_err_i(cache_resp_err_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, exp finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ic_req_vld_i = 0; ic_req_addr_i = '0; ic_resp_rdy_i = 0;
        dc_req_vld_i = 0; dc_req_rd_i = 0; dc_req_addr_i = '0; dc_req_wdata_i = '0; dc_resp_rdy_i = 0;
        cache_req_rdy_i = 0; cache_resp_vld_i = 0; cache_resp_rdata_i = '0; cache_resp_err_i = 0;
        tick(); tick();

        // reset state
        chk("rst_req_vld", cache_req_vld_o, 0);
        chk("rst_resp_rdy", cache_resp_rdy_o, 0);
        chk("rst_addr", cache_req_addr_o, 0);
        chk("rst_ic_vld", ic_resp_vld_o, 0);
        chk("rst_dc_vld", dc_resp_vld_o, 0);
        rst_n = 1'b1;
        tick();

        // icache read
        ic_req_vld_i = 1; ic_req_addr_i = 64'h8000_1234; cache_req_rdy_i = 1;
        #1 chk("ic_rdy", ic_req_rdy_o, 1);
        chk("ic_dc_rdy", dc_req_rdy_o, 0);
        tick(); ic_req_vld_i = 0;
        chk("ic_fwd_vld", cache_req_vld_o, 1);
        chk("ic_fwd_addr", cache_req_addr_o, 64'h8000_1200);
        chk("ic_fwd_rd", cache_req_rd_o, 1);
        chk("ic_fwd_wdata", cache_req_wdata_o, 0);
        tick(); cache_req_rdy_i = 0;
        chk("ic_wait_rdy", cache_resp_rdy_o, 1);
        chk("ic_one_req", cache_req_vld_o, 0);
        tick(); tick();
        cache_resp_vld_i = 1; cache_resp_rdata_i = PAT_A; cache_resp_err_i = 0;
        tick(); cache_resp_vld_i = 0; cache_resp_rdata_i = '0;
        chk("ic_resp_vld", ic_resp_vld_o, 1);
        chk("ic_resp_data", ic_resp_rdata_o, PAT_A);
        chk("ic_resp_err", ic_resp_err_o, 0);
        chk("ic_dc_vld", dc_resp_vld_o, 0);
        chk("ic_dc_data", dc_resp_rdata_o, 0);
        ic_resp_rdy_i = 1;
        tick(); ic_resp_rdy_i = 0;
        chk("ic_done", ic_resp_vld_o, 0);

        // dcache write with downstream backpressure
        dc_req_vld_i = 1; dc_req_rd_i = 0; dc_req_addr_i = 64'h40; dc_req_wdata_i = PAT_B;
        #1 chk("dc_rdy", dc_req_rdy_o, 1);
        tick(); dc_req_vld_i = 0; dc_req_wdata_i = '0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) cache_req_rdy_i = 1;
            chk("dcw_vld", cache_req_vld_o, 1);
            chk("dcw_addr", cache_req_addr_o, 64'h40);
            chk("dcw_wdata", cache_req_wdata_o, PAT_B);
            chk("dcw_rd", cache_req_rd_o, 0);
            tick();
        end
        cache_req_rdy_i = 0;
        chk("dcw_wait", cache_resp_rdy_o, 1);
        cache_resp_vld_i = 1; cache_resp_rdata_i = PAT_C; cache_resp_err_i = 1;
        tick(); cache_resp_vld_i = 0; cache_resp_err_i = 0;
        chk("dcw_resp_vld", dc_resp_vld_o, 1);
        chk("dcw_resp_err", dc_resp_err_o, 1);
        chk("dcw_ic_vld", ic_resp_vld_o, 0);
        dc_resp_rdy_i = 1;
        tick(); dc_resp_rdy_i = 0;

        // round robin with both clients requesting, from a fresh reset
        rst_n = 0; tick(); rst_n = 1;
        ic_req_vld_i = 1; ic_req_addr_i = 64'h100;
        dc_req_vld_i = 1; dc_req_rd_i = 1; dc_req_addr_i = 64'h2FF;
        cache_req_rdy_i = 1; ic_resp_rdy_i = 1; dc_resp_rdy_i = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ic_rdy", ic_req_rdy_o, (k % 2) == 0);
            chk("rr_dc_rdy", dc_req_rdy_o, (k % 2) == 1);
            tick();
            chk("rr_vld", cache_req_vld_o, 1);
            chk("rr_addr", cache_req_addr_o, ((k % 2) == 0) ? 64'h100 : 64'h2C0);
            tick();
            chk("rr_one_req", cache_req_vld_o, 0);
            cache_resp_vld_i = 1; cache_resp_rdata_i = LINE_W'(k);
            tick(); cache_resp_vld_i = 0;
            chk("rr_owner", ((k % 2) == 0) ? ic_resp_vld_o : dc_resp_vld_o, 1);
            chk("rr_other", ((k % 2) == 0) ? dc_resp_vld_o : ic_resp_vld_o, 0);
            tick();
        end
        ic_req_vld_i = 0; dc_req_vld_i = 0; ic_resp_rdy_i = 0; dc_resp_rdy_i = 0;

        // response backpressure on the dcache; the icache waits meanwhile
        dc_req_vld_i = 1; dc_req_addr_i = 64'h1_0000;
        #1 chk("bp_dc_rdy", dc_req_rdy_o, 1);
        tick(); dc_req_vld_i = 0;
        tick();
        cache_resp_vld_i = 1; cache_resp_rdata_i = PAT_D;
        tick(); cache_resp_vld_i = 0; cache_resp_rdata_i = '0;
        ic_req_vld_i = 1; ic_req_addr_i = 64'h8000_0047;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) dc_resp_rdy_i = 1;
            #1;
            chk("bp_vld", dc_resp_vld_o, 1);
            chk("bp_data", dc_resp_rdata_o, PAT_D);
            chk("bp_no_gnt", ic_req_rdy_o, 0);
            tick();
        end
        dc_resp_rdy_i = 0;
        chk("bp_done", dc_resp_vld_o, 0);
        chk("bp_gnt_ic", ic_req_rdy_o, 1);

        // reset during WAIT, with the icache still requesting
        tick();
        chk("rw_req", cache_req_vld_o, 1);
        tick(); cache_req_rdy_i = 0;
        chk("rw_wait", cache_resp_rdy_o, 1);
        rst_n = 0;
        tick();
        chk("rw_req_vld", cache_req_vld_o, 0);
        chk("rw_resp_rdy", cache_resp_rdy_o, 0);
        chk("rw_ic_rdy", ic_req_rdy_o, 0);
        chk("rw_addr", cache_req_addr_o, 0);
        chk("rw_ic_vld", ic_resp_vld_o, 0);
        rst_n = 1;
        #1 chk("rw_regrant", ic_req_rdy_o, 1);
        tick(); ic_req_vld_i = 0;
        chk("rw_fwd_addr", cache_req_addr_o, 64'h8000_0040);
        cache_req_rdy_i = 1;
        tick(); cache_req_rdy_i = 0;
        cache_resp_vld_i = 1;
        tick(); cache_resp_vld_i = 0;
        ic_resp_rdy_i = 1;
        tick(); ic_resp_rdy_i = 0;

`ifdef CACHE_ARB_TIMEOUT_EN
        // watchdog: no response, then a late pulse is absorbed
        begin
            int n;
            dc_req_vld_i = 1; dc_req_rd_i = 1; dc_req_addr_i = 64'h1000; cache_req_rdy_i = 1;
            tick(); dc_req_vld_i = 0;
            tick(); cache_req_rdy_i = 0;
            n = 0;
            while (!dc_resp_vld_o && n < 50) begin
                tick();
                n++;
            end
            chk("to_latency", LINE_W'(n), LINE_W'(9));
            ic_req_vld_i = 1; ic_req_addr_i = 64'h200;
            #1;
            chk("to_err", dc_resp_err_o, 1);
            chk("to_data", dc_resp_rdata_o, 0);
            chk("to_no_gnt_resp", ic_req_rdy_o, 0);
            dc_resp_rdy_i = 1;
            tick(); dc_resp_rdy_i = 0;
            #1;
            chk("to_block", ic_req_rdy_o, 0);
            chk("to_drop_rdy", cache_resp_rdy_o, 1);
            tick(); tick();
            chk("to_block2", ic_req_rdy_o, 0);
            cache_resp_vld_i = 1; cache_resp_rdata_i = PAT_A;
            tick(); cache_resp_vld_i = 0;
            #1;
            chk("to_resume", ic_req_rdy_o, 1);
            chk("to_rdy_clr", cache_resp_rdy_o, 0);
            chk("to_no_resp", dc_resp_vld_o | ic_resp_vld_o, 0);
            ic_req_vld_i = 0;
            tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
